display_list_player: RTL and testbench
======================================

// Module: display_list_player
// PURPOSE
//   Command initiator for the vector beam controller: fetches display-list words from a
//   synchronous ROM/RAM and issues jump/draw commands with x/y, pacing itself on the
//   controller's ready. Sits between display-list memory and the beam controller;
//   replays the list continuously, one pass per frame.
// PARAMETERS
//   ADDR_W     10  display-list address width (list holds 2**ADDR_W words)
//   START_ADDR  0  address of first word of a frame
//   HOLDOFF     2  cycles after a strobe during which ready is ignored (min 1)
// PORTS
//   clk        in   1   system clock, all logic on rising edge
//   reset_n    in   1   asynchronous reset, active low
//   enable     in   1   1 = run list; 0 = pause after current command
//   mem_addr   out  ADDR_W  display-list read address
//   mem_rd     out  1   read strobe; mem_data valid exactly 1 cycle later
//   mem_data   in   26  [25:24] opcode, [23:12] x, [11:0] y/count
//   ready      in   1   beam controller ready for next command
//   x          out  12  target x, stable from strobe until next strobe
//   y          out  12  target y, stable from strobe until next strobe
//   jump       out  1   one-cycle pulse: move beam to (x,y) blanked
//   draw       out  1   one-cycle pulse: draw line to (x,y)
//   frame_done out  1   one-cycle pulse when END executed or address wraps
//   busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
//   Reset: mem_addr=START_ADDR, mem_rd=0, x=y=0, jump=draw=frame_done=0, busy=0, state IDLE.
//   Opcodes: 00 JUMP, 01 DRAW, 10 END (next addr = START_ADDR, pulse frame_done),
//     11 WAIT (idle for mem_data[11:0] cycles; 0 = no delay; x/y unchanged).
//   States: IDLE -> FETCH -> DATA -> EXEC -> (HOLD -> WAITRDY | DELAY) -> FETCH/IDLE.
//   IDLE: leave when enable=1 && ready=1.
//   FETCH: mem_rd=1 for one cycle at mem_addr. DATA: capture mem_data into cmd register.
//   EXEC: JUMP/DRAW only when ready=1 (else stay): load x/y and pulse jump or draw in
//     the same cycle x/y update; go HOLD. END: pulse frame_done, addr<=START_ADDR.
//     WAIT: load counter, go DELAY (count 0 -> straight on).
//   HOLD: HOLDOFF cycles ignoring ready (controller ready lags strobe), then WAITRDY.
//   WAITRDY/DELAY done: addr<=addr+1, then FETCH if enable=1 else IDLE (address kept,
//     resume continues from next word; no replay of the executed word).
//   Fetch-to-strobe latency with ready high: 3 cycles (FETCH, DATA, EXEC).
//   Address wrap: addr 2**ADDR_W-1 increments to START_ADDR and pulses frame_done
//     on the increment cycle; END at last address produces only one pulse.
//   jump and draw never both high; never high in consecutive cycles (edge-detect safe).
//   enable drop mid-command: command completes incl. HOLD/WAITRDY, then IDLE.
//   reset_n low mid-command: all outputs to reset values immediately (async).
//   Empty list (END at START_ADDR): frame_done every 3 cycles, no jump/draw.
// STRUCTURE
//   vector_pkg: OP_JUMP/OP_DRAW/OP_END/OP_WAIT constants, CMD_W=26, COORD_W=12,
//     field slice localparams; shared with controller and list assembler tooling.
//   Single module, no sub-module; counter for HOLD/DELAY shared (12 bits).
// TESTING
//   Reset: hold reset_n low mid-DRAW -> all outputs 0, mem_addr=START_ADDR at once.
//   List {JUMP(100,200),DRAW(4095,0),END}, ready stuck 1 -> jump with x=100,y=200 at
//     cycle 3 after first mem_rd, draw with x=4095,y=0, frame_done, then replay.
//   Ready low for 50 cycles after each strobe -> next mem_rd only after ready rises;
//     x/y unchanged during wait; exactly one strobe per command.
//   WAIT count=10 between two JUMPs -> jump pulses separated by >=10+3 cycles; WAIT 0
//     behaves as NOP.
//   enable dropped during DRAW HOLD -> draw completes, busy falls, mem_addr = next word;
//     re-enable -> fetch resumes at that address, no duplicate draw.
//   ADDR_W=2, list of 4 JUMPs, no END -> wrap to START_ADDR with one frame_done per pass.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared definitions for the vector beam pipeline: display-list word layout and opcodes.
// Used by the list player, the beam controller and the list assembler tooling.
package vector_pkg;

  localparam int CMD_W   = 26;
  localparam int COORD_W = 12;

  localparam int OP_HI = 25;
  localparam int OP_LO = 24;
  localparam int X_HI  = 23;
  localparam int X_LO  = 12;
  localparam int Y_HI  = 11;
  localparam int Y_LO  = 0;

  typedef enum logic [1:0] {
    OP_JUMP = 2'b00,
    OP_DRAW = 2'b01,
    OP_END  = 2'b10,
    OP_WAIT = 2'b11
  } opcode_t;

  // Field order matches the slice localparams above; y doubles as the WAIT count.
  typedef struct packed {
    opcode_t              op;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
  } cmd_t;

endpackage

// File: rtl/display_list_player.sv
// Display-list player: fetches list words from synchronous memory and issues
// jump/draw strobes with x/y to the beam controller, replaying the list every frame.
module display_list_player
  import vector_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int START_ADDR = 0,
  parameter int HOLDOFF    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [CMD_W-1:0]   mem_data,
  input  logic               ready,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               jump,
  output logic               draw,
  output logic               frame_done,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DATA,
    S_EXEC,
    S_HOLD,
    S_WAITRDY,
    S_DELAY
  } state_t;

  localparam logic [ADDR_W-1:0]  FIRST_ADDR = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = '1;
  localparam logic [COORD_W-1:0] HOLD_LOAD  = COORD_W'(HOLDOFF - 1);

  state_t               state, state_next;
  cmd_t                 cmd;
  logic [ADDR_W-1:0]    addr;
  logic [COORD_W-1:0]   cnt;
  logic [COORD_W-1:0]   cnt_load_val;
  logic                 cnt_load, cnt_dec;
  logic                 do_strobe, do_end, do_advance;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    state_next   = state;
    do_strobe    = 1'b0;
    do_end       = 1'b0;
    do_advance   = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = HOLD_LOAD;
    cnt_dec      = 1'b0;

    unique case (state)
      S_IDLE:  if (enable && ready) state_next = S_FETCH;
      S_FETCH: state_next = S_DATA;
      S_DATA:  state_next = S_EXEC;
      S_EXEC: begin
        case (cmd.op)
          OP_JUMP, OP_DRAW: begin
            if (ready) begin
              do_strobe  = 1'b1;
              cnt_load   = 1'b1;
              state_next = S_HOLD;
            end
          end
          OP_END: begin
            do_end     = 1'b1;
            state_next = enable ? S_FETCH : S_IDLE;
          end
          OP_WAIT: begin
            if (cmd.y == '0) begin
              do_advance = 1'b1;
              state_next = enable ? S_FETCH : S_IDLE;
            end else begin
              cnt_load     = 1'b1;
              cnt_load_val = cmd.y;
              state_next   = S_DELAY;
            end
          end
        endcase
      end
      // The controller's ready lags the strobe, so it is ignored for HOLDOFF cycles.
      S_HOLD: begin
        if (cnt == '0) state_next = S_WAITRDY;
        else           cnt_dec    = 1'b1;
      end
      S_WAITRDY: begin
        if (ready) begin
          do_advance = 1'b1;
          state_next = enable ? S_FETCH : S_IDLE;
        end
      end
      S_DELAY: begin
        if (cnt == COORD_W'(1)) begin
          do_advance = 1'b1;
          state_next = enable ? S_FETCH : S_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr       <= FIRST_ADDR;
      cmd        <= '0;
      cnt        <= '0;
      x          <= '0;
      y          <= '0;
      jump       <= 1'b0;
      draw       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      jump       <= do_strobe && (cmd.op == OP_JUMP);
      draw       <= do_strobe && (cmd.op == OP_DRAW);
      // END and a wrap are mutually exclusive cycles, so END at the last word pulses once.
      frame_done <= do_end || (do_advance && (addr == LAST_ADDR));

      if (state == S_DATA) cmd <= cmd_t'(mem_data);

      if (do_strobe) begin
        x <= cmd.x;
        y <= cmd.y;
      end

      if (cnt_load)     cnt <= cnt_load_val;
      else if (cnt_dec) cnt <= cnt - 1'b1;

      if (do_end)          addr <= FIRST_ADDR;
      else if (do_advance) addr <= (addr == LAST_ADDR) ? FIRST_ADDR : addr + 1'b1;
    end
  end

  assign mem_addr = addr;
  assign mem_rd   = (state == S_FETCH);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_display_list_player.sv
// Directed bench for display_list_player: event tables for list playback plus
// hand-written sequences for ready pacing, enable pause, async reset and address wrap.
module tb_display_list_player;

  localparam int AW  = 10;
  localparam int AW2 = 2;
  localparam logic [1:0] C_JUMP = 2'b00, C_DRAW = 2'b01, C_END = 2'b10, C_WAIT = 2'b11;
  localparam logic [2:0] K_J = 3'b001, K_D = 3'b010, K_F = 3'b100;

  typedef struct {
    int         cyc;
    logic [2:0] kind;   // {frame_done, draw, jump}
    logic [11:0] x;
    logic [11:0] y;
  } ev_t;

  typedef struct {
    int cyc;
    int addr;
  } rd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n, enable, ready, enable2, ready2;
  logic [AW-1:0]  mem_addr;
  logic           mem_rd, jump, draw, frame_done, busy;
  logic [25:0]    mem_data;
  logic [11:0]    x, y;
  logic [AW2-1:0] mem2_addr;
  logic           mem2_rd, jump2, draw2, frame_done2, busy2;
  logic [25:0]    mem2_data;
  logic [11:0]    x2, y2;

  logic [25:0] mem  [0:(1<<AW)-1];
  logic [25:0] mem2 [0:(1<<AW2)-1];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  viol     = 0;
  bit  mon_sel  = 1'b0;
  bit  prev1    = 1'b0;
  bit  prev2    = 1'b0;
  ev_t ev_q[$];
  rd_t rd_q[$];
  ev_t exp_q[$];
  ev_t ev_tmp;
  rd_t rd_tmp;

  display_list_player #(.ADDR_W(AW), .START_ADDR(0), .HOLDOFF(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .ready(ready), .x(x), .y(y), .jump(jump), .draw(draw),
    .frame_done(frame_done), .busy(busy)
  );

  display_list_player #(.ADDR_W(AW2), .START_ADDR(0), .HOLDOFF(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable2), .mem_addr(mem2_addr), .mem_rd(mem2_rd),
    .mem_data(mem2_data), .ready(ready2), .x(x2), .y(y2), .jump(jump2), .draw(draw2),
    .frame_done(frame_done2), .busy(busy2)
  );

  // Synchronous list memories: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd)  mem_data  <= mem[mem_addr];
    if (mem2_rd) mem2_data <= mem2[mem2_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (jump && draw) viol++;
      if ((jump || draw) && prev1) viol++;
      if (jump2 && draw2) viol++;
      if ((jump2 || draw2) && prev2) viol++;
      prev1 = jump || draw;
      prev2 = jump2 || draw2;
      if (!mon_sel) begin
        if (jump || draw || frame_done) begin
          ev_tmp.cyc = cyc; ev_tmp.kind = {frame_done, draw, jump}; ev_tmp.x = x; ev_tmp.y = y;
          ev_q.push_back(ev_tmp);
        end
        if (mem_rd) begin
          rd_tmp.cyc = cyc; rd_tmp.addr = int'(mem_addr);
          rd_q.push_back(rd_tmp);
        end
      end else begin
        if (jump2 || draw2 || frame_done2) begin
          ev_tmp.cyc = cyc; ev_tmp.kind = {frame_done2, draw2, jump2}; ev_tmp.x = x2; ev_tmp.y = y2;
          ev_q.push_back(ev_tmp);
        end
        if (mem2_rd) begin
          rd_tmp.cyc = cyc; rd_tmp.addr = int'(mem2_addr);
          rd_q.push_back(rd_tmp);
        end
      end
    end else begin
      prev1 = 1'b0;
      prev2 = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] enc(input logic [1:0] op, input int cx, input int cy);
    logic [11:0] xs, ys;
    xs = cx[11:0];
    ys = cy[11:0];
    return {op, xs, ys};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic add_exp(input int rel, input logic [2:0] kind, input int ex, input int ey);
    ev_t e;
    e.cyc = rel; e.kind = kind; e.x = ex[11:0]; e.y = ey[11:0];
    exp_q.push_back(e);
  endtask

  task automatic compare_events(input string tag);
    check({tag, " event count"}, 32'(ev_q.size() >= exp_q.size()), 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < ev_q.size()) begin
        check($sformatf("%s ev%0d cycle", tag, i), ev_q[i].cyc - ev_q[0].cyc, exp_q[i].cyc);
        check($sformatf("%s ev%0d kind", tag, i), 32'(ev_q[i].kind), 32'(exp_q[i].kind));
        check($sformatf("%s ev%0d x", tag, i), 32'(ev_q[i].x), 32'(exp_q[i].x));
        check($sformatf("%s ev%0d y", tag, i), 32'(ev_q[i].y), 32'(exp_q[i].y));
      end
    end
    exp_q.delete();
  endtask

  // what: 0 jump, 1 draw, 2 mem_rd, 3 not busy (all on the main instance)
  task automatic wait_for(input int what, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (what)
        0:       hit = jump;
        1:       hit = draw;
        2:       hit = mem_rd;
        default: hit = !busy;
      endcase
    end
    check({name, " reached"}, 32'(hit), 1);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    enable2 = 1'b0;
    ready   = 1'b1;
    ready2  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    ev_q.delete();
    rd_q.delete();
  endtask

  initial begin
    int n_rd, n_str, xy_bad, t, n_draw;
    logic [11:0] sx, sy;

    // Reset state
    apply_reset();
    for (int i = 0; i < 16; i++) mem[i] = enc(C_END, 0, 0);
    mem[0] = enc(C_JUMP, 100, 200);
    mem[1] = enc(C_DRAW, 4095, 0);
    mem[2] = enc(C_END, 0, 0);
    check("reset mem_addr", 32'(mem_addr), 0);
    check("reset mem_rd", 32'(mem_rd), 0);
    check("reset x", 32'(x), 0);
    check("reset y", 32'(y), 0);
    check("reset strobes", 32'({jump, draw, frame_done}), 0);
    check("reset busy", 32'(busy), 0);

    // Basic list with ready stuck high, two passes
    enable = 1'b1;
    release_reset();
    repeat (45) @(negedge clk);
    check("basic rd count", 32'(rd_q.size() >= 5), 1);
    check("basic ev seen", 32'(ev_q.size() >= 1), 1);
    if (rd_q.size() >= 5 && ev_q.size() >= 1) begin
      check("basic fetch-to-jump latency", ev_q[0].cyc - rd_q[0].cyc, 3);
      check("basic rd0 addr", rd_q[0].addr, 0);
      check("basic rd1 addr", rd_q[1].addr, 1);
      check("basic rd2 addr", rd_q[2].addr, 2);
      check("basic replay addr", rd_q[3].addr, 0);
      check("basic replay rd spacing", rd_q[3].cyc - rd_q[2].cyc, 3);
    end
    add_exp(0,  K_J, 100, 200);
    add_exp(6,  K_D, 4095, 0);
    add_exp(12, K_F, 4095, 0);
    add_exp(15, K_J, 100, 200);
    add_exp(21, K_D, 4095, 0);
    add_exp(27, K_F, 4095, 0);
    compare_events("basic");

    // Asynchronous reset in the middle of a DRAW
    wait_for(1, 40, "mid-draw");
    #1 reset_n = 1'b0;
    #1;
    check("async rst draw", 32'(draw), 0);
    check("async rst x", 32'(x), 0);
    check("async rst y", 32'(y), 0);
    check("async rst mem_addr", 32'(mem_addr), 0);
    check("async rst busy", 32'(busy), 0);
    check("async rst mem_rd", 32'(mem_rd), 0);

    // Ready held low for 50 cycles after each strobe
    apply_reset();
    mem[0] = enc(C_JUMP, 10, 20);
    mem[1] = enc(C_DRAW, 30, 40);
    mem[2] = enc(C_END, 0, 0);
    enable = 1'b1;
    release_reset();
    for (int k = 0; k < 2; k++) begin
      wait_for(k, 60, $sformatf("pace strobe%0d", k));
      ready = 1'b0;
      sx = x;
      sy = y;
      check($sformatf("pace x%0d", k), 32'(sx), (k == 0) ? 10 : 30);
      check($sformatf("pace y%0d", k), 32'(sy), (k == 0) ? 20 : 40);
      n_rd = 0; n_str = 0; xy_bad = 0;
      repeat (50) begin
        @(negedge clk);
        if (mem_rd) n_rd++;
        if (jump || draw) n_str++;
        if (x != sx || y != sy) xy_bad++;
      end
      ready = 1'b1;
      check($sformatf("pace%0d rd while waiting", k), n_rd, 0);
      check($sformatf("pace%0d extra strobes", k), n_str, 0);
      check($sformatf("pace%0d xy moved", k), xy_bad, 0);
      t = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        t++;
        if (mem_rd) break;
      end
      check($sformatf("pace%0d rd after ready", k), t, 1);
    end

    // WAIT 10 and WAIT 0 between JUMPs
    apply_reset();
    mem[0] = enc(C_JUMP, 1, 1);
    mem[1] = enc(C_WAIT, 0, 10);
    mem[2] = enc(C_JUMP, 2, 2);
    mem[3] = enc(C_WAIT, 0, 0);
    mem[4] = enc(C_JUMP, 3, 3);
    mem[5] = enc(C_END, 0, 0);
    enable = 1'b1;
    release_reset();
    repeat (60) @(negedge clk);
    add_exp(0,  K_J, 1, 1);
    add_exp(19, K_J, 2, 2);
    add_exp(28, K_J, 3, 3);
    add_exp(34, K_F, 3, 3);
    add_exp(37, K_J, 1, 1);
    compare_events("wait");

    // enable dropped during DRAW hold, then resumed
    apply_reset();
    mem[0] = enc(C_JUMP, 5, 6);
    mem[1] = enc(C_DRAW, 7, 8);
    mem[2] = enc(C_JUMP, 9, 9);
    mem[3] = enc(C_END, 0, 0);
    enable = 1'b1;
    release_reset();
    wait_for(1, 40, "pause draw");
    enable = 1'b0;
    wait_for(3, 20, "pause idle");
    check("pause mem_addr", 32'(mem_addr), 2);
    check("pause x", 32'(x), 7);
    check("pause y", 32'(y), 8);
    n_rd = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_rd || busy) n_rd++;
    end
    check("pause stays idle", n_rd, 0);
    enable = 1'b1;
    wait_for(2, 5, "resume fetch");
    check("resume mem_addr", 32'(mem_addr), 2);
    wait_for(0, 10, "resume jump");
    check("resume x", 32'(x), 9);
    n_draw = 0;
    foreach (ev_q[i]) if (ev_q[i].kind == K_D) n_draw++;
    check("resume draw count", n_draw, 1);

    // ADDR_W=2 list of four JUMPs, no END: wrap gives one frame_done per pass
    apply_reset();
    for (int i = 0; i < 4; i++) mem2[i] = enc(C_JUMP, i + 1, 10 * (i + 1));
    mon_sel = 1'b1;
    enable2 = 1'b1;
    release_reset();
    repeat (60) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) add_exp(24 * p + 6 * i, K_J, i + 1, 10 * (i + 1));
      add_exp(24 * p + 21, K_F, 4, 40);
    end
    add_exp(48, K_J, 1, 10);
    compare_events("wrap");

    check("strobe overlap/back-to-back", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
